// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

   // Bus ownership state: idle, data port, fetch port, or draining a flushed cycle.
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_D = 2'd1,
      ARB_GRANT_I = 2'd2,
      ARB_DRAIN   = 2'd3
   } arb_state_e;

   localparam int          STALL_W   = 6;
   localparam int          STAGE_IF  = 1;      // IF/ID bit of the stall vector
   localparam int          STAGE_MEM = 4;      // MEM/WB bit of the stall vector
   localparam logic [31:0] ZERO_WORD = 32'h0;
   localparam logic [3:0]  SEL_ALL   = 4'hF;

endpackage

// File: rtl/arb_result_buf.sv
// Per-port result holder: keeps a completed bus result while the consuming
// pipeline stage is stalled, so the bus can be released immediately.
module arb_result_buf
   import mem_bus_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        complete,
   input  logic        stage_stall,
   input  logic        flush,
   input  logic [31:0] data,
   output logic        done,
   output logic [31:0] held
);

   // Latch a result that completes under stall; release when the stage advances.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      if (rst) begin
         done <= 1'b0;
         held <= ZERO_WORD;
      end else if (flush) begin
         done <= 1'b0;
      end else if (complete && stage_stall) begin
         done <= 1'b1;
         held <= data;
      end else if (!stage_stall) begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style bus between the fetch port and the load/store
// port. Data accesses win ties; each bus cycle is followed by a dead cycle.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               if_ce_i,
   input  logic [31:0]        if_addr_i,
   output logic [31:0]        if_data_o,
   output logic               stallreq_if_o,
   input  logic               mem_ce_i,
   input  logic               mem_we_i,
   input  logic [3:0]         mem_sel_i,
   input  logic [31:0]        mem_addr_i,
   input  logic [31:0]        mem_data_i,
   output logic [31:0]        mem_data_o,
   output logic               stallreq_mem_o,
   output logic               bus_cyc_o,
   output logic               bus_stb_o,
   output logic               bus_we_o,
   output logic [3:0]         bus_sel_o,
   output logic [31:0]        bus_addr_o,
   output logic [31:0]        bus_data_o,
   input  logic [31:0]        bus_data_i,
   input  logic               bus_ack_i,
   output logic               bus_err_o
);

   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   // Timeout fires in the MAX_WAIT-th unacknowledged cycle of a bus cycle.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

   arb_state_e       state, next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             cap_we;
   logic [3:0]       cap_sel;
   logic [31:0]      cap_addr, cap_wdata;
   logic             busy, timeout, ack_eff;
   logic [31:0]      rdata;
   logic             d_complete, i_complete;
   logic             d_done, i_done;
   logic [31:0]      d_held, i_held;
   logic             unused_stall;

   assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

   assign busy       = (state != ARB_IDLE);
   assign timeout    = (MAX_WAIT != 0) && busy && !bus_ack_i && (wait_cnt == WAIT_LAST);
   assign ack_eff    = busy && (bus_ack_i || timeout);
   assign rdata      = timeout ? ZERO_WORD : bus_data_i;
   assign d_complete = (state == ARB_GRANT_D) && ack_eff && !flush_i;
   assign i_complete = (state == ARB_GRANT_I) && ack_eff && !flush_i;

   // State register; async reset drops the bus cycle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARB_IDLE;
      else     state <= next_state;
   end

   // Next-state logic: data priority from IDLE, leave on (real or forced) ack.
   always_comb begin
      // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         ARB_IDLE: begin
            if (!flush_i) begin
               if (mem_ce_i && !d_done)     next_state = ARB_GRANT_D;
               else if (if_ce_i && !i_done) next_state = ARB_GRANT_I;
            end
         end
         ARB_GRANT_D, ARB_GRANT_I: begin
            if (ack_eff)      next_state = ARB_IDLE;
            else if (flush_i) next_state = ARB_DRAIN;
         end
         ARB_DRAIN: begin
            if (ack_eff) next_state = ARB_IDLE;
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   // Capture the granted port's request so the bus is stable for the whole cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_we    <= 1'b0;
         cap_sel   <= 4'h0;
         cap_addr  <= ZERO_WORD;
         cap_wdata <= ZERO_WORD;
      end else if (state == ARB_IDLE && next_state == ARB_GRANT_D) begin
         cap_we    <= mem_we_i;
         cap_sel   <= mem_sel_i;
         cap_addr  <= mem_addr_i;
         cap_wdata <= mem_data_i;
      end else if (state == ARB_IDLE && next_state == ARB_GRANT_I) begin
         cap_we    <= 1'b0;
         cap_sel   <= SEL_ALL;
         cap_addr  <= if_addr_i;
         cap_wdata <= ZERO_WORD;
      end
   end

   // Watchdog: restart on every state change, count cycles spent waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              wait_cnt <= '0;
      else if (busy && next_state == state) wait_cnt <= wait_cnt + 1'b1;
      else                                  wait_cnt <= '0;
   end

   arb_result_buf u_d_buf (
      .clk         (clk),
      .rst         (rst),
      .complete    (d_complete),
      .stage_stall (stall_i[STAGE_MEM]),
      .flush       (flush_i),
      .data        (rdata),
      .done        (d_done),
      .held        (d_held)
   );

   arb_result_buf u_i_buf (
      .clk         (clk),
      .rst         (rst),
      .complete    (i_complete),
      .stage_stall (stall_i[STAGE_IF]),
      .flush       (flush_i),
      .data        (rdata),
      .done        (i_done),
      .held        (i_held)
   );

   assign bus_cyc_o  = busy;
   assign bus_stb_o  = busy;
   assign bus_we_o   = busy && cap_we;
   assign bus_sel_o  = busy ? cap_sel   : 4'h0;
   assign bus_addr_o = busy ? cap_addr  : ZERO_WORD;
   assign bus_data_o = busy ? cap_wdata : ZERO_WORD;
   assign bus_err_o  = timeout;

   // Completing data is forwarded combinationally; otherwise the held result or zero.
   assign mem_data_o     = d_complete ? rdata : (d_done ? d_held : ZERO_WORD);
   assign if_data_o      = i_complete ? rdata : (i_done ? i_held : ZERO_WORD);
   assign stallreq_mem_o = mem_ce_i && !d_done && !d_complete;
   assign stallreq_if_o  = if_ce_i  && !i_done && !i_complete;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: bus transactions are scoreboarded against a queue of
// expected requests; port results and stall timing are checked per cycle.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } bus_txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = 6'h0;
   logic        flush = 1'b0;
   logic        if_ce = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        mem_ce = 1'b0;
   logic        mem_we = 1'b0;
   logic [3:0]  mem_sel = 4'h0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [31:0] if_data, mem_rdata, bus_addr, bus_wdata;
   logic        stallreq_if, stallreq_mem, bus_cyc, bus_stb, bus_we, bus_err;
   logic [3:0]  bus_sel;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   // Second instance with a short watchdog and a slave that never answers.
   logic        wd_mem_ce = 1'b0;
   logic        wd_if_ce = 1'b0;
   logic        wd_ack = 1'b0;
   logic [31:0] wd_bus_rdata = 32'hFFFF_FFFF;
   logic [31:0] wd_if_data, wd_mem_data, wd_bus_addr, wd_bus_wdata;
   logic        wd_stallreq_if, wd_stallreq_mem, wd_cyc, wd_stb, wd_we, wd_err;
   logic [3:0]  wd_sel;

   int          s_wait = 0;
   int          s_cnt = 0;
   logic [31:0] s_rdata = 32'h0;

   int          errors = 0;
   int          checks = 0;
   bus_txn_t    exp_q[$];
   bus_txn_t    mon_e;
   logic        cyc_prev = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter u_dut (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .stallreq_if_o(stallreq_if),
      .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
      .mem_data_i(mem_wdata), .mem_data_o(mem_rdata), .stallreq_mem_o(stallreq_mem),
      .bus_cyc_o(bus_cyc), .bus_stb_o(bus_stb), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
      .bus_addr_o(bus_addr), .bus_data_o(bus_wdata), .bus_data_i(bus_rdata),
      .bus_ack_i(bus_ack), .bus_err_o(bus_err)
   );

   mem_bus_arbiter #(.MAX_WAIT(4)) u_dut_wd (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .if_ce_i(wd_if_ce), .if_addr_i(if_addr), .if_data_o(wd_if_data), .stallreq_if_o(wd_stallreq_if),
      .mem_ce_i(wd_mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
      .mem_data_i(mem_wdata), .mem_data_o(wd_mem_data), .stallreq_mem_o(wd_stallreq_mem),
      .bus_cyc_o(wd_cyc), .bus_stb_o(wd_stb), .bus_we_o(wd_we), .bus_sel_o(wd_sel),
      .bus_addr_o(wd_bus_addr), .bus_data_o(wd_bus_wdata), .bus_data_i(wd_bus_rdata),
      .bus_ack_i(wd_ack), .bus_err_o(wd_err)
   );

   // Slave model: acknowledges after s_wait wait states.
   always_ff @(posedge clk) begin
      if (!bus_cyc || bus_ack) s_cnt <= 0;
      else                     s_cnt <= s_cnt + 1;
   end
   assign bus_ack   = bus_cyc && (s_cnt == s_wait);
   assign bus_rdata = s_rdata;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic void expect_txn(input logic [31:0] addr, input logic we,
                                      input logic [3:0] sel, input logic [31:0] wdata);
      exp_q.push_back('{addr: addr, we: we, sel: sel, wdata: wdata});
   endfunction

   // Bus monitor: every new bus cycle must match the oldest expected request.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus_cyc && !cyc_prev) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_addr", bus_addr, mon_e.addr);
               check("sb_we", {31'h0, bus_we}, {31'h0, mon_e.we});
               check("sb_sel", {28'h0, bus_sel}, {28'h0, mon_e.sel});
               check("sb_wdata", bus_wdata, mon_e.wdata);
               check("sb_stb", {31'h0, bus_stb}, 32'd1);
            end
         end
         cyc_prev = bus_cyc;
      end
   end

   initial begin
      int  d_cyc, i_cyc, gap, if_bad, drain_cyc, wd_cycles, err_cnt;
      bit  d_ack_seen, i_ack_seen, got;

      // Reset state
      sample();
      check("rst_cyc", {31'h0, bus_cyc}, 32'd0);
      check("rst_addr", bus_addr, 32'h0);
      check("rst_err", {31'h0, bus_err}, 32'd0);
      check("rst_ifdata", if_data, 32'h0);
      check("rst_memdata", mem_rdata, 32'h0);
      tick();
      rst = 1'b0;
      sample();

      // 1: zero-wait fetch
      tick();
      s_wait = 0; s_rdata = 32'h3C01_0001;
      if_ce = 1'b1; if_addr = 32'h0;
      expect_txn(32'h0, 1'b0, 4'hF, 32'h0);
      sample();
      check("t1_stall_idle", {31'h0, stallreq_if}, 32'd1);
      check("t1_cyc_idle", {31'h0, bus_cyc}, 32'd0);
      tick();
      sample();
      check("t1_cyc_grant", {31'h0, bus_cyc}, 32'd1);
      check("t1_stall_ack", {31'h0, stallreq_if}, 32'd0);
      check("t1_ifdata", if_data, 32'h3C01_0001);
      tick();
      if_ce = 1'b0;
      sample();
      check("t1_cyc_after", {31'h0, bus_cyc}, 32'd0);
      check("t1_ifdata_idle", if_data, 32'h0);

      // 2: simultaneous requests, 3-wait slave, data goes first
      tick();
      s_wait = 3; s_rdata = 32'h8C22_0004;
      mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100; mem_wdata = 32'h0;
      if_ce = 1'b1; if_addr = 32'h4;
      expect_txn(32'h100, 1'b0, 4'hF, 32'h0);
      expect_txn(32'h4, 1'b0, 4'hF, 32'h0);
      sample();
      check("t2_stall_mem", {31'h0, stallreq_mem}, 32'd1);
      check("t2_stall_if", {31'h0, stallreq_if}, 32'd1);
      d_cyc = 0; i_cyc = 0; gap = 0; if_bad = 0; d_ack_seen = 0; i_ack_seen = 0;
      for (int c = 0; c < 30 && !i_ack_seen; c++) begin
         tick();
         if (d_ack_seen) mem_ce = 1'b0;
         sample();
         if (bus_cyc && bus_addr == 32'h100) begin
            d_cyc++;
            if (bus_ack) begin
               check("t2_memdata", mem_rdata, 32'h8C22_0004);
               d_ack_seen = 1;
            end
         end else if (bus_cyc && bus_addr == 32'h4) begin
            i_cyc++;
            if (bus_ack) begin
               check("t2_ifdata", if_data, 32'h8C22_0004);
               i_ack_seen = 1;
            end
         end else if (d_ack_seen && i_cyc == 0) begin
            gap++;
         end
         if (!i_ack_seen && !stallreq_if) if_bad++;
      end
      check("t2_fetch_done", {31'h0, i_ack_seen}, 32'd1);
      check("t2_data_cycles", d_cyc, 32'd4);
      check("t2_dead_cycles", gap, 32'd1);
      check("t2_fetch_cycles", i_cyc, 32'd4);
      check("t2_if_stalled", if_bad, 32'd0);
      tick();
      if_ce = 1'b0; mem_ce = 1'b0;
      sample();

      // 3: load completes under MEM/WB stall and is held
      tick();
      s_wait = 0; s_rdata = 32'hDEAD_BEEF;
      stall = 6'b011111;
      mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200; mem_wdata = 32'h0;
      expect_txn(32'h200, 1'b0, 4'hF, 32'h0);
      sample();
      check("t3_stall_idle", {31'h0, stallreq_mem}, 32'd1);
      tick();
      sample();
      check("t3_ack_data", mem_rdata, 32'hDEAD_BEEF);
      check("t3_ack_stall", {31'h0, stallreq_mem}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         tick();
         sample();
         check("t3_held_data", mem_rdata, 32'hDEAD_BEEF);
         check("t3_held_stall", {31'h0, stallreq_mem}, 32'd0);
         check("t3_no_regrant", {31'h0, bus_cyc}, 32'd0);
      end
      tick();
      stall = 6'h0;
      sample();
      check("t3_release_data", mem_rdata, 32'hDEAD_BEEF);
      check("t3_release_cyc", {31'h0, bus_cyc}, 32'd0);
      tick();
      mem_ce = 1'b0;
      sample();
      check("t3_cleared_data", mem_rdata, 32'h0);
      check("t3_cleared_cyc", {31'h0, bus_cyc}, 32'd0);

      // 4: flush during a 5-wait fetch drains the cycle
      tick();
      s_wait = 5; s_rdata = 32'hBADB_AD00;
      if_ce = 1'b1; if_addr = 32'h10;
      expect_txn(32'h10, 1'b0, 4'hF, 32'h0);
      sample();
      tick();
      sample();
      check("t4_cyc1", {31'h0, bus_cyc}, 32'd1);
      tick();
      flush = 1'b1;
      sample();
      check("t4_flush_stall", {31'h0, stallreq_if}, 32'd1);
      tick();
      flush = 1'b0; if_addr = 32'h20;
      expect_txn(32'h20, 1'b0, 4'hF, 32'h0);
      sample();
      check("t4_drain_state", 32'(u_dut.state), 32'(ARB_DRAIN));
      drain_cyc = 0; if_bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (!bus_cyc) break;
         drain_cyc++;
         if (if_data != 32'h0 || !stallreq_if) if_bad++;
         tick();
         sample();
      end
      check("t4_drain_cycles", drain_cyc, 32'd4);
      check("t4_drain_discard", if_bad, 32'd0);
      check("t4_idle_stall", {31'h0, stallreq_if}, 32'd1);
      tick();
      s_wait = 0; s_rdata = 32'h1234_5678;
      sample();
      check("t4_refetch_cyc", {31'h0, bus_cyc}, 32'd1);
      check("t4_refetch_data", if_data, 32'h1234_5678);
      tick();
      if_ce = 1'b0;
      sample();

      // 4b: flush in the very ack cycle discards the result
      tick();
      s_wait = 0; s_rdata = 32'h0BAD_0001;
      if_ce = 1'b1; if_addr = 32'h30;
      expect_txn(32'h30, 1'b0, 4'hF, 32'h0);
      expect_txn(32'h30, 1'b0, 4'hF, 32'h0);
      sample();
      tick();
      flush = 1'b1; stall = 6'b000010;
      sample();
      check("t4b_ack_stall", {31'h0, stallreq_if}, 32'd1);
      check("t4b_ack_data", if_data, 32'h0);
      tick();
      flush = 1'b0; stall = 6'h0; s_rdata = 32'h2402_0030;
      sample();
      check("t4b_idle_cyc", {31'h0, bus_cyc}, 32'd0);
      check("t4b_idle_stall", {31'h0, stallreq_if}, 32'd1);
      tick();
      sample();
      check("t4b_regrant_data", if_data, 32'h2402_0030);
      tick();
      if_ce = 1'b0;
      sample();

      // 5: watchdog with MAX_WAIT = 4 and a silent slave
      tick();
      mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
      wd_mem_ce = 1'b1;
      sample();
      check("t5_stall_idle", {31'h0, wd_stallreq_mem}, 32'd1);
      wd_cycles = 0; err_cnt = 0; got = 0;
      for (int c = 0; c < 12 && !got; c++) begin
         tick();
         sample();
         if (wd_cyc) wd_cycles++;
         if (wd_err) begin
            err_cnt++;
            got = 1;
            check("t5_timeout_data", wd_mem_data, 32'h0);
            check("t5_timeout_stall", {31'h0, wd_stallreq_mem}, 32'd0);
            check("t5_cyc_count", wd_cycles, 32'd4);
         end
      end
      check("t5_timeout_seen", {31'h0, got}, 32'd1);
      tick();
      wd_mem_ce = 1'b0;
      sample();
      check("t5_cyc_dropped", {31'h0, wd_cyc}, 32'd0);
      check("t5_err_pulse", {31'h0, wd_err}, 32'd0);

      // 6: async reset in the middle of a store cycle
      tick();
      s_wait = 10;
      mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h400; mem_wdata = 32'hCAFE_F00D;
      expect_txn(32'h400, 1'b1, 4'b0011, 32'hCAFE_F00D);
      sample();
      tick();
      sample();
      check("t6_grant_cyc", {31'h0, bus_cyc}, 32'd1);
      tick();
      rst = 1'b1; mem_ce = 1'b0;
      #1;
      check("t6_rst_cyc", {31'h0, bus_cyc}, 32'd0);
      check("t6_rst_we", {31'h0, bus_we}, 32'd0);
      check("t6_rst_addr", bus_addr, 32'h0);
      check("t6_rst_wdata", bus_wdata, 32'h0);
      check("t6_rst_state", 32'(u_dut.state), 32'(ARB_IDLE));
      tick();
      rst = 1'b0;
      sample();
      check("t6_after_cyc", {31'h0, bus_cyc}, 32'd0);

      check("sb_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
